vector_element_sequencer: RTL and testbench

- Multi-cycle controller that steps the vector datapath one element at a time, from vstart up to vl-1.
- For each element it issues the element index, the byte offset and an active (mask) flag to the datapath, using a valid/ready handshake.
- It stalls the scalar PC while busy and writes vstart back on completion (0) or abort (the interrupted index).
- It sits between instruction decode (start/config) and the vector register and memory datapath.

---
 rtl/vec_seq_pkg.sv | 16 +
 rtl/vec_elem_offset.sv | 22 ++
 rtl/vector_element_sequencer.sv | 120 ++++++++++++
 tb/tb_vector_element_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// rtl/vec_seq_pkg.sv - shared types and constants for the vector element sequencer
package vec_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam logic [2:0] SEW8  = 3'd0;
    localparam logic [2:0] SEW16 = 3'd1;
    localparam logic [2:0] SEW32 = 3'd2;

    localparam logic [2:0] SEW_MAX_LEGAL = SEW32;

endpackage

// File: rtl/vec_elem_offset.sv
// rtl/vec_elem_offset.sv - element index to byte offset, shared with the load/store unit
module vec_elem_offset
    import vec_seq_pkg::*;
#(
    parameter int IDX_W = 32
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [2:0]       sew,
    output logic [IDX_W-1:0] byte_off
);

    always_comb begin
        byte_off = idx;
        case (sew)
            SEW8:    byte_off = idx;
            SEW16:   byte_off = idx << 1;
            SEW32:   byte_off = idx << 2;
            default: byte_off = idx << sew;
        endcase
    end

endmodule

// File: rtl/vector_element_sequencer.sv
// rtl/vector_element_sequencer.sv - steps the vector datapath one element at a time
module vector_element_sequencer
    import vec_seq_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int IDX_W = 32
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset_n,
    input  logic             start,
    output logic             start_ready,
    input  logic [IDX_W-1:0] cfg_vl,
    input  logic [IDX_W-1:0] cfg_vstart,
    input  logic [2:0]       cfg_vsew,
    input  logic             cfg_vm,
    input  logic             cfg_vill,
    input  logic [VLEN-1:0]  masks,
    output logic             elem_valid,
    input  logic             elem_ready,
    output logic [IDX_W-1:0] elem_idx,
    output logic [IDX_W-1:0] elem_byte_off,
    output logic             elem_active,
    output logic             elem_last,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             vstart_we,
    output logic [IDX_W-1:0] new_vstart
);

    localparam int MW = $clog2(VLEN);

    seq_state_e       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] vl_q;
    logic [2:0]       sew_q;
    logic             vm_q;
    logic [VLEN-1:0]  masks_q;

    logic [IDX_W-1:0] vl_clamp;
    logic             cfg_bad;

    assign vl_clamp = (cfg_vl > IDX_W'(VLEN)) ? IDX_W'(VLEN) : cfg_vl;
    assign cfg_bad  = cfg_vill || (cfg_vsew > SEW_MAX_LEGAL);

    assign start_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign elem_valid  = (state == ST_RUN);
    assign elem_idx    = idx;
    assign elem_active = vm_q | masks_q[idx[MW-1:0]];
    assign elem_last   = (idx == vl_q - IDX_W'(1));

    vec_elem_offset #(.IDX_W(IDX_W)) u_offset (
        .idx      (idx),
        .sew      (sew_q),
        .byte_off (elem_byte_off)
    );

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            vl_q       <= '0;
            sew_q      <= '0;
            vm_q       <= 1'b0;
            masks_q    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            vstart_we  <= 1'b0;
            new_vstart <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            vstart_we  <= 1'b0;
            new_vstart <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            vl_q    <= vl_clamp;
                            sew_q   <= cfg_vsew;
                            vm_q    <= cfg_vm;
                            masks_q <= masks;
                            idx     <= cfg_vstart;
                            if (cfg_vstart >= vl_clamp) begin
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                vstart_we <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    // abort wins over a same-cycle handshake: that element is replayed on resume
                    if (abort) begin
                        state      <= ST_IDLE;
                        vstart_we  <= 1'b1;
                        new_vstart <= idx;
                    end else if (elem_ready) begin
                        if (elem_last) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            vstart_we <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_element_sequencer.sv
// tb/tb_vector_element_sequencer.sv - self-checking bench for vector_element_sequencer
module tb_vector_element_sequencer;

    logic         SYS_clk = 1'b0;
    logic         SYS_reset_n;
    logic         start;
    logic         start_ready;
    logic [31:0]  cfg_vl;
    logic [31:0]  cfg_vstart;
    logic [2:0]   cfg_vsew;
    logic         cfg_vm;
    logic         cfg_vill;
    logic [127:0] masks;
    logic         elem_valid;
    logic         elem_ready;
    logic [31:0]  elem_idx;
    logic [31:0]  elem_byte_off;
    logic         elem_active;
    logic         elem_last;
    logic         abort;
    logic         busy;
    logic         done;
    logic         err;
    logic         vstart_we;
    logic [31:0]  new_vstart;

    vector_element_sequencer #(.VLEN(128), .IDX_W(32)) dut (
        .SYS_clk       (SYS_clk),
        .SYS_reset_n   (SYS_reset_n),
        .start         (start),
        .start_ready   (start_ready),
        .cfg_vl        (cfg_vl),
        .cfg_vstart    (cfg_vstart),
        .cfg_vsew      (cfg_vsew),
        .cfg_vm        (cfg_vm),
        .cfg_vill      (cfg_vill),
        .masks         (masks),
        .elem_valid    (elem_valid),
        .elem_ready    (elem_ready),
        .elem_idx      (elem_idx),
        .elem_byte_off (elem_byte_off),
        .elem_active   (elem_active),
        .elem_last     (elem_last),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .vstart_we     (vstart_we),
        .new_vstart    (new_vstart)
    );

    always #5 SYS_clk = ~SYS_clk;

    typedef struct {
        int           vl;
        int           vstart;
        logic [2:0]   sew;
        bit           vill;
        bit           vm;
        logic [127:0] msk;
        logic [15:0]  pat;
        int           abort_at;
        bit           exp_err;
    } vec_t;

    vec_t          tbl [10];
    logic [65:0]   sb [$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            done_cnt = 0, err_cnt = 0, vsw_cnt = 0, hs_cnt = 0, done_cyc = 0;
    logic [31:0]   last_nv = '0;
    bit            busy_seen = 0;
    bit            stall_prev = 0;
    logic [65:0]   prev_el = '0;

    always @(posedge SYS_clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge SYS_clk) begin
        logic [65:0] cur;
        cur = {elem_idx, elem_byte_off, elem_active, elem_last};
        if (!SYS_reset_n) begin
            stall_prev = 0;
        end else begin
            if (busy) busy_seen = 1;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (vstart_we) begin vsw_cnt++; last_nv = new_vstart; end
            if (stall_prev && elem_valid) chk("stall_hold", cur, prev_el);
            if (elem_valid && elem_ready && !abort) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_elem: got idx %0d expected none", elem_idx);
                end else begin
                    chk("elem", cur, sb.pop_front());
                end
            end
            stall_prev = elem_valid && !elem_ready;
            prev_el = cur;
        end
    end

    task automatic run_vec(input vec_t v);
        int n, cnt, d0, e0, w0, h0, s_cyc;
        logic [31:0] ii;
        bit timed_out;
        n = (v.vl > 128) ? 128 : v.vl;
        cnt = 0;
        if (!v.exp_err) begin
            for (int i = v.vstart; i < n; i++) begin
                if (v.abort_at >= 0 && i >= v.vstart + v.abort_at) break;
                ii = i;
                sb.push_back({ii, ii << v.sew, v.vm | v.msk[i], (i == n - 1)});
                cnt++;
            end
        end
        d0 = done_cnt; e0 = err_cnt; w0 = vsw_cnt; h0 = hs_cnt;
        busy_seen = 0;
        @(posedge SYS_clk); #1;
        cfg_vl = v.vl; cfg_vstart = v.vstart; cfg_vsew = v.sew;
        cfg_vm = v.vm; cfg_vill = v.vill; masks = v.msk;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge SYS_clk); #1;
        start = 1'b0;
        cfg_vl = $urandom; cfg_vstart = $urandom; cfg_vm = ~v.vm; masks = ~v.msk;
        timed_out = 1;
        for (int k = 0; k < 200; k++) begin
            elem_ready = (k < 16) ? v.pat[k] : 1'b1;
            abort = (k == v.abort_at);
            @(posedge SYS_clk); #1;
            if (!busy) begin timed_out = 0; break; end
        end
        abort = 1'b0;
        elem_ready = 1'b0;
        chk("timeout", timed_out, 1'b0);
        repeat (2) @(posedge SYS_clk);
        #1;
        if (v.exp_err) begin
            chk("err_cnt", err_cnt - e0, 1);
            chk("err_quiet", {busy_seen, 32'(done_cnt - d0), 32'(vsw_cnt - w0)}, 0);
        end else if (v.abort_at >= 0) begin
            chk("abort_done", done_cnt - d0, 0);
            chk("abort_vsw", {32'(vsw_cnt - w0), last_nv}, {32'd1, 32'(v.vstart + v.abort_at)});
            chk("abort_sb", sb.size(), 0);
        end else begin
            chk("done_vsw", {32'(done_cnt - d0), 32'(vsw_cnt - w0), last_nv, 32'(err_cnt - e0)},
                {32'd1, 32'd1, 32'd0, 32'd0});
            chk("hs_count", {32'(hs_cnt - h0), 32'(sb.size())}, {32'(cnt), 32'd0});
            if (v.pat == 16'hFFFF) chk("latency", done_cyc - s_cyc, cnt + 1);
        end
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        tbl[0] = '{4,   0, 3'd2, 0, 1, 128'h0,    16'hFFFF, -1, 0};
        tbl[1] = '{4,   0, 3'd0, 0, 0, 128'hA,    16'hFFFF, -1, 0};
        tbl[2] = '{3,   0, 3'd1, 0, 1, 128'h0,    16'hFFF9, -1, 0};
        tbl[3] = '{5,   5, 3'd0, 0, 1, 128'h0,    16'hFFFF, -1, 0};
        tbl[4] = '{8,   0, 3'd2, 0, 1, 128'h0,    16'hFFFF,  3, 0};
        tbl[5] = '{8,   3, 3'd2, 0, 0, 128'hA5,   16'hFFFF, -1, 0};
        tbl[6] = '{4,   0, 3'd0, 1, 1, 128'h0,    16'hFFFF, -1, 1};
        tbl[7] = '{4,   0, 3'd3, 0, 1, 128'h0,    16'hFFFF, -1, 1};
        tbl[8] = '{200, 125, 3'd0, 0, 0, {1'b1, 127'h0}, 16'hFFFF, -1, 0};
        tbl[9] = '{6,   2, 3'd1, 0, 0, 128'h14,   16'hB5D5, -1, 0};

        SYS_reset_n = 1'b0;
        start = 0; cfg_vl = 0; cfg_vstart = 0; cfg_vsew = 0; cfg_vm = 0; cfg_vill = 0;
        masks = '0; elem_ready = 0; abort = 0;
        repeat (2) @(posedge SYS_clk);
        #1;
        chk("reset_outs", {start_ready, busy, elem_valid, done, err, vstart_we, new_vstart,
                           elem_idx, elem_byte_off, elem_active, elem_last},
            {1'b1, 5'b0, 32'd0, 32'd0, 32'd0, 2'b0});
        SYS_reset_n = 1'b1;
        @(posedge SYS_clk); #1;

        for (int t = 0; t < 10; t++) run_vec(tbl[t]);

        d0 = done_cnt; w0 = vsw_cnt;
        @(posedge SYS_clk); #1;
        cfg_vl = 8; cfg_vstart = 2; cfg_vsew = 0; cfg_vm = 1; cfg_vill = 0; start = 1'b1;
        @(posedge SYS_clk); #1;
        start = 1'b0;
        chk("run_first_valid", {start_ready, busy, elem_valid, elem_idx}, {3'b011, 32'd2});
        @(posedge SYS_clk); #1;
        SYS_reset_n = 1'b0;
        #1;
        chk("rst_mid", {start_ready, busy, elem_valid, done, vstart_we, elem_idx},
            {1'b1, 4'b0, 32'd0});
        repeat (2) @(posedge SYS_clk);
        #1;
        SYS_reset_n = 1'b1;
        repeat (2) @(posedge SYS_clk);
        #1;
        chk("rst_release", {start_ready, busy, 32'(done_cnt - d0), 32'(vsw_cnt - w0)},
            {2'b10, 32'd0, 32'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
